// File: rtl/lsu_ctrl_if.sv
// Core request/response and data RAM signals of the load/store unit.
// The slave modport is the LSU side, the master modport the core/RAM side.
interface lsu_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] data_ram_addr_o;
    logic [31:0] data_ram_wr_data_o;
    logic        data_ram_wr_en_o;
    logic [31:0] data_ram_rd_data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  data_ram_rd_data_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output data_ram_addr_o, data_ram_wr_data_o, data_ram_wr_en_o
    );

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        output data_ram_rd_data_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  data_ram_addr_o, data_ram_wr_data_o, data_ram_wr_en_o
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-outstanding RV32I load/store controller over a word-wide RAM.
// Optional LSU_MISALIGN_TRAP_EN faults misaligned H/W accesses instead of aligning them.
module lsu_ctrl (
    input  logic      clk,
    input  logic      rst,
    lsu_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RSP  = 2'd3;

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic        err_q;

    logic        accept;
    logic        legal;
    logic        fault;
    logic [31:0] addr_al;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    function automatic logic [31:0] load_ext(
        input logic [2:0]  f3,
        input logic [1:0]  off,
        input logic [31:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    // Sub-word store: replace only the addressed lane of the old word.
    function automatic logic [31:0] merge(
        input logic [2:0]  f3,
        input logic [1:0]  off,
        input logic [31:0] old,
        input logic [31:0] wd
    );
        merge = old;
        if (f3[0])
            merge[{off[1], 4'b0000} +: 16] = wd[15:0];
        else
            merge[{off, 3'b000} +: 8] = wd[7:0];
    endfunction

    always_comb begin
        accept = bus.req_valid_i && (state == IDLE);
        if (bus.req_we_i)
            legal = bus.req_funct3_i inside {3'b000, 3'b001, 3'b010};
        else
            legal = !(bus.req_funct3_i inside {3'b011, 3'b110, 3'b111});
        addr_al = bus.req_addr_i;
        case (bus.req_funct3_i[1:0])
            2'b01:   addr_al[0] = 1'b0;
            2'b10:   addr_al[1:0] = 2'b00;
            default: addr_al = bus.req_addr_i;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        case (bus.req_funct3_i[1:0])
            2'b01:   misalign = bus.req_addr_i[0];
            2'b10:   misalign = |bus.req_addr_i[1:0];
            default: misalign = 1'b0;
        endcase
        fault = !legal || misalign;
`else
        fault = !legal;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= addr_al;
                        wdata_q <= bus.req_wdata_i;
                        f3_q    <= bus.req_funct3_i;
                        we_q    <= bus.req_we_i;
                        if (fault) begin
                            state   <= RSP;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else if (bus.req_we_i && bus.req_funct3_i == 3'b010) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (we_q) begin
                        word_q <= bus.data_ram_rd_data_i;
                        state  <= WR;
                    end else begin
                        rdata_q <= load_ext(f3_q, addr_q[1:0], bus.data_ram_rd_data_i);
                        err_q   <= 1'b0;
                        state   <= RSP;
                    end
                end
                WR: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state   <= RSP;
                end
                RSP: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.req_ready_o        = (state == IDLE);
        bus.rsp_valid_o        = (state == RSP);
        bus.rsp_rdata_o        = rdata_q;
        bus.rsp_err_o          = err_q;
        bus.data_ram_addr_o    = '0;
        bus.data_ram_wr_data_o = '0;
        bus.data_ram_wr_en_o   = 1'b0;
        if (state == RD || state == WR)
            bus.data_ram_addr_o = addr_q;
        if (state == WR) begin
            bus.data_ram_wr_en_o   = !rst;
            bus.data_ram_wr_data_o = f3_q[1] ? wdata_q
                                   : merge(f3_q, addr_q[1:0], word_q, wdata_q);
        end
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge; rst  in  1  synchronous, active-high reset.
REQ-002 SHALL have ports: req_valid_i  in  1  core memory request; req_ready_o  out  1  request accepted when both high.
REQ-003 SHALL have ports: req_we_i  in  1  1=store, 0=load; req_funct3_i  in  3  RV32I size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-004 SHALL have ports: req_addr_i  in  32  byte address; req_wdata_i  in  32  store data, low bits significant.
REQ-005 SHALL have ports: rsp_valid_o  out  1  one-cycle completion pulse; rsp_rdata_o  out  32  load result; rsp_err_o  out  1  access fault.
REQ-006 SHALL have ports: data_ram_addr_o  out  32  byte address, RAM indexes by addr>>2; data_ram_wr_data_o  out  32  full word; data_ram_wr_en_o  out  1  word write, takes effect on the next rising edge; data_ram_rd_data_i  in  32  combinational read of the addressed word.

Function
REQ-007 SHALL implement the FSM states IDLE, RD, WR, RSP; req_ready_o = (state==IDLE).
REQ-008 SHALL latch addr, we, funct3 and wdata on acceptance; inputs are ignored outside IDLE.
REQ-009 Load path SHALL be IDLE->RD->RSP->IDLE; in RD it drives data_ram_addr_o = latched addr and registers data_ram_rd_data_i.
REQ-010 SW path SHALL be IDLE->WR->RSP->IDLE; in WR it sets wr_en=1 and wr_data=wdata.
REQ-011 SB/SH path SHALL be IDLE->RD->WR->RSP->IDLE; RD captures the old word, and WR writes the old word with only the addressed byte/halfword lane replaced.
REQ-012 Lanes SHALL be little-endian: byte lane = addr[1:0], halfword lane = addr[1].
REQ-013 Load extraction: LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL return the word unchanged.
REQ-014 rsp_valid_o SHALL be 1 only in RSP, for exactly one cycle; the next request can be accepted the cycle after RSP.
REQ-015 Latency from the accept edge to rsp_valid_o SHALL be: loads 2 cycles, SW 2 cycles, SB/SH 3 cycles, faults 1 cycle.
REQ-016 rsp_rdata_o SHALL be 0 for stores and faulted accesses; it is valid only while rsp_valid_o=1.
REQ-017 Illegal funct3 (011, 110, 111 for loads; anything other than 000/001/010 for stores) SHALL go IDLE->RSP with rsp_err_o=1, no RAM access and no write.
REQ-018 data_ram_wr_en_o SHALL be 1 only in WR and never while rst=1.
REQ-019 Outside RD/WR, data_ram_addr_o and data_ram_wr_data_o SHALL be 0.

Reset
REQ-020 While rst=1 at a clock edge: state->IDLE; latched regs, rsp_valid_o, rsp_err_o and rsp_rdata_o ->0.
REQ-021 Reset during RD, WR or RSP SHALL abort the operation: no write is issued in the reset cycle, and no response is produced for the aborted request.
REQ-022 req_ready_o SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-023 Macro LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0, SHALL fault per REQ-017 (IDLE->RSP, err=1, no write).
REQ-024 Macro LSU_MISALIGN_TRAP_EN undefined: the misaligned offset is cleared (H: addr[0]=0, W: addr[1:0]=0), the access proceeds normally, and rsp_err_o is only raised for illegal funct3.

Verification
REQ-025 LW: RAM word 1 = 0x8899AABB; LW addr 0x4 -> rsp_valid_o 2 cycles after accept, rdata=0x8899AABB, err=0.
REQ-026 LB/LBU: RAM word 1 = 0x8899AABB; LB addr 0x6 -> 0xFFFFFF99; LBU addr 0x6 -> 0x00000099; LHU addr 0x6 -> 0x00008899.
REQ-027 SB RMW: word 2 = 0x11223344; SB addr 0x9, wdata 0xFFFFFFAB -> exactly one wr_en pulse, word 2 = 0x1122AB44, rsp 3 cycles after accept.
REQ-028 Misaligned: SW addr 0x2 with macro defined -> err=1 after 1 cycle, no wr_en, RAM unchanged; without macro -> word 0 written, err=0.
REQ-029 Reset mid-op: assert rst during the WR cycle of an SH -> wr_en_o=0 that cycle, RAM unchanged, no rsp_valid_o, req_ready_o=1 after release.
REQ-030 Back-to-back: hold req_valid_i high with SW then LW to the same address -> second request accepted the cycle after the first RSP and returns the stored value.
